// File: rtl/rf_wb_arbiter_pkg.sv
// rtl/rf_wb_arbiter_pkg.sv - shared register-index and data types for the writeback arbiter
package rf_wb_arbiter_pkg;
    typedef logic [4:0]  reg_ind_t;
    typedef logic [31:0] data_t;

    localparam reg_ind_t REG_ZERO = 5'd0;
endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - per-register pending bits for in-flight long-latency ops
import rf_wb_arbiter_pkg::*;

module rf_scoreboard #(
    parameter int NUM_REGS = 32
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     set_en,
    input  reg_ind_t set_idx,
    input  logic     clr_en,
    input  reg_ind_t clr_idx,
    input  reg_ind_t chk_rs1,
    input  reg_ind_t chk_rs2,
    input  reg_ind_t chk_rd,
    output logic     hz_rs1,
    output logic     hz_rs2,
    output logic     hz_rd
);

    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_d;

    always_comb begin
        pending_d = pending_q;
        if (clr_en) pending_d[clr_idx] = 1'b0;
        if (set_en) pending_d[set_idx] = 1'b1;
        // x0 can never carry an outstanding result
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pending_q <= '0;
        else     pending_q <= pending_d;
    end

    assign hz_rs1 = pending_q[chk_rs1];
    assign hz_rs2 = pending_q[chk_rs2];
    assign hz_rd  = pending_q[chk_rd];

endmodule

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - arbitrates the RegFile write port between pipeline WB and the long-latency unit
import rf_wb_arbiter_pkg::*;

module rf_wb_arbiter #(
    parameter int MAX_WAIT = 2,
    parameter int NUM_REGS = 32
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     id_valid,
    input  reg_ind_t id_rs1,
    input  reg_ind_t id_rs2,
    input  reg_ind_t id_rd,
    input  logic     id_rd_we,
    input  logic     id_long,
    output logic     id_stall,
    input  logic     pwb_valid,
    input  reg_ind_t pwb_rd,
    input  data_t    pwb_data,
    output logic     pwb_ready,
    input  logic     lu_valid,
    input  reg_ind_t lu_rd,
    input  data_t    lu_data,
    output logic     lu_ready,
    output logic     rf_we,
    output reg_ind_t rf_waddr,
    output data_t    rf_wdata
);

    localparam int WCW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
    logic           rf_we_q, rf_we_d;
    reg_ind_t       rf_waddr_q, rf_waddr_d;
    data_t          rf_wdata_q, rf_wdata_d;

    logic hz_rs1, hz_rs2, hz_rd;
    logic lu_prio, pwb_acc, lu_acc, issue_long;

    rf_scoreboard #(.NUM_REGS(NUM_REGS)) u_sb (
        .clk     (clk),
        .rst     (rst),
        .set_en  (issue_long),
        .set_idx (id_rd),
        .clr_en  (lu_acc),
        .clr_idx (lu_rd),
        .chk_rs1 (id_rs1),
        .chk_rs2 (id_rs2),
        .chk_rd  (id_rd),
        .hz_rs1  (hz_rs1),
        .hz_rs2  (hz_rs2),
        .hz_rd   (hz_rd)
    );

    assign id_stall   = id_valid & (hz_rs1 | hz_rs2 | (id_rd_we & hz_rd));
    assign issue_long = id_valid & ~id_stall & id_rd_we & id_long & (id_rd != REG_ZERO);

    // A long result refused MAX_WAIT times takes the port; WB must hold its request
    assign lu_prio   = lu_valid & (int'(wait_cnt_q) >= MAX_WAIT);
    assign pwb_ready = ~lu_prio;
    assign lu_ready  = lu_prio | ~pwb_valid;
    assign pwb_acc   = pwb_valid & pwb_ready;
    assign lu_acc    = lu_valid & lu_ready & ~pwb_acc;

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!lu_valid || lu_acc)
            wait_cnt_d = '0;
        else if (int'(wait_cnt_q) < MAX_WAIT)
            wait_cnt_d = wait_cnt_q + WCW'(1);
    end

    always_comb begin
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (lu_acc) begin
            rf_we_d    = (lu_rd != REG_ZERO);
            rf_waddr_d = lu_rd;
            rf_wdata_d = lu_data;
        end else if (pwb_acc) begin
            rf_we_d    = (pwb_rd != REG_ZERO);
            rf_waddr_d = pwb_rd;
            rf_wdata_d = pwb_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_q <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - self-checking bench for rf_wb_arbiter with a write scoreboard
import rf_wb_arbiter_pkg::*;

module tb_rf_wb_arbiter;

    logic     clk = 1'b0;
    logic     rst;
    logic     id_valid, id_rd_we, id_long, id_stall;
    reg_ind_t id_rs1, id_rs2, id_rd;
    logic     pwb_valid, pwb_ready;
    reg_ind_t pwb_rd;
    data_t    pwb_data;
    logic     lu_valid, lu_ready;
    reg_ind_t lu_rd;
    data_t    lu_data;
    logic     rf_we;
    reg_ind_t rf_waddr;
    data_t    rf_wdata;

    typedef struct packed {
        reg_ind_t a;
        data_t    d;
    } wr_t;
    wr_t exp_q[$];

    int checks = 0;
    int passed = 0;

    rf_wb_arbiter #(.MAX_WAIT(2), .NUM_REGS(32)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rd_we(id_rd_we), .id_long(id_long), .id_stall(id_stall),
        .pwb_valid(pwb_valid), .pwb_rd(pwb_rd), .pwb_data(pwb_data), .pwb_ready(pwb_ready),
        .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_data(lu_data), .lu_ready(lu_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
    );

    always #5 clk = ~clk;

    // Every registered write must match the oldest expected write
    always @(negedge clk) begin
        if (!rst && rf_we === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL rf_write_unexpected: got addr=%0d data=%h, required no write", rf_waddr, rf_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (rf_waddr !== e.a || rf_wdata !== e.d)
                    $display("FAIL rf_write: got addr=%0d data=%h, required addr=%0d data=%h",
                             rf_waddr, rf_wdata, e.a, e.d);
                else
                    passed++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_rd_we = 0; id_long = 0;
        pwb_valid = 0; pwb_rd = 0; pwb_data = 0;
        lu_valid = 0; lu_rd = 0; lu_data = 0;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) $display("FAIL %s: got %h, required %h", name, got, exp);
        else passed++;
    endtask

    task automatic issue_long(input reg_ind_t rd);
        id_valid = 1; id_rd = rd; id_rd_we = 1; id_long = 1; id_rs1 = 0; id_rs2 = 0;
    endtask

    task automatic test_reset();
        idle();
        pwb_valid = 1; pwb_rd = 2; pwb_data = 32'h22;
        lu_valid = 1; lu_rd = 4; lu_data = 32'h44;
        rst = 1;
        #3;
        chk("reset_rf_we", {31'd0, rf_we}, 32'd0);
        chk("reset_pending", dut.u_sb.pending_q, 32'd0);
        chk("reset_wait_cnt", 32'(dut.wait_cnt_q), 32'd0);
        tick();
        rst = 0;
        exp_q.push_back('{a: 5'd2, d: 32'h22});
        #1;
        chk("post_reset_pwb_ready", {31'd0, pwb_ready}, 32'd1);
        chk("post_reset_lu_ready", {31'd0, lu_ready}, 32'd0);
        tick();
        idle();
        tick();
    endtask

    task automatic test_raw();
        issue_long(5);
        #1;
        chk("raw_issue_nostall", {31'd0, id_stall}, 32'd0);
        tick();
        id_rd_we = 0; id_long = 0; id_rs1 = 5; id_rd = 0;
        #1;
        chk("raw_stall", {31'd0, id_stall}, 32'd1);
        tick();
        lu_valid = 1; lu_rd = 5; lu_data = 32'hDEAD;
        #1;
        chk("raw_lu_ready", {31'd0, lu_ready}, 32'd1);
        chk("raw_stall_accept_cycle", {31'd0, id_stall}, 32'd1);
        exp_q.push_back('{a: 5'd5, d: 32'hDEAD});
        tick();
        lu_valid = 0;
        #1;
        chk("raw_rf_waddr", 32'(rf_waddr), 32'd5);
        chk("raw_stall_released", {31'd0, id_stall}, 32'd0);
        idle();
        tick();
    endtask

    task automatic test_starvation();
        int wcnt = 0;
        bit lu_done = 0;
        idle();
        lu_valid = 1; lu_rd = 11; lu_data = 32'hBEEF;
        for (int c = 0; c < 4; c++) begin
            logic exp_lu;
            pwb_valid = 1; pwb_rd = 10; pwb_data = 32'h1000 + c;
            lu_valid = !lu_done;
            exp_lu = lu_valid && (wcnt >= 2);
            #1;
            chk($sformatf("starve_pwb_ready_c%0d", c), {31'd0, pwb_ready}, {31'd0, !exp_lu});
            chk($sformatf("starve_lu_ready_c%0d", c), {31'd0, lu_ready & lu_valid}, {31'd0, exp_lu});
            if (exp_lu) begin
                exp_q.push_back('{a: 5'd11, d: 32'hBEEF});
                lu_done = 1;
                wcnt = 0;
            end else begin
                exp_q.push_back('{a: 5'd10, d: 32'h1000 + c});
                if (lu_valid) wcnt++;
                else wcnt = 0;
            end
            tick();
        end
        idle();
        tick();
    endtask

    task automatic test_x0();
        idle();
        lu_valid = 1; lu_rd = 0; lu_data = 32'h1234;
        issue_long(0);
        #1;
        chk("x0_lu_ready", {31'd0, lu_ready}, 32'd1);
        chk("x0_nostall", {31'd0, id_stall}, 32'd0);
        tick();
        idle();
        chk("x0_no_write", {31'd0, rf_we}, 32'd0);
        chk("x0_pending_clear", dut.u_sb.pending_q, 32'd0);
        tick();
    endtask

    task automatic test_waw();
        idle();
        issue_long(7);
        tick();
        id_long = 0; id_rd = 7; id_rd_we = 1; id_rs1 = 1; id_rs2 = 1;
        #1;
        chk("waw_stall", {31'd0, id_stall}, 32'd1);
        id_rd_we = 0;
        #1;
        chk("waw_no_we_nostall", {31'd0, id_stall}, 32'd0);
        idle();
        lu_valid = 1; lu_rd = 7; lu_data = 32'h77;
        exp_q.push_back('{a: 5'd7, d: 32'h77});
        tick();
        idle();
        tick();
    endtask

    task automatic test_set_and_clear();
        idle();
        issue_long(9);
        tick();
        issue_long(3);
        lu_valid = 1; lu_rd = 9; lu_data = 32'h99;
        #1;
        chk("setclr_nostall", {31'd0, id_stall}, 32'd0);
        exp_q.push_back('{a: 5'd9, d: 32'h99});
        tick();
        idle();
        chk("setclr_pending3", {31'd0, dut.u_sb.pending_q[3]}, 32'd1);
        chk("setclr_pending9", {31'd0, dut.u_sb.pending_q[9]}, 32'd0);
        id_valid = 1; id_rs1 = 9;
        #1;
        chk("setclr_rs9_nostall", {31'd0, id_stall}, 32'd0);
        id_rs1 = 3;
        #1;
        chk("setclr_rs3_stall", {31'd0, id_stall}, 32'd1);
        idle();
        lu_valid = 1; lu_rd = 3; lu_data = 32'h33;
        exp_q.push_back('{a: 5'd3, d: 32'h33});
        tick();
        idle();
        tick();
    endtask

    initial begin
        idle();
        rst = 1;
        test_reset();
        test_raw();
        test_starvation();
        test_x0();
        test_waw();
        test_set_and_clear();
        repeat (3) tick();
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Schedules the register file's single write port between two producers: the in-order pipeline writeback stage and a long-latency unit (load miss path / multiplier-divider).
- Keeps a per-register pending scoreboard for issued long-latency ops. Raises a stall to the decode stage on RAW/WAW hazards against those ops.
- Sits between the WB stage, the long-latency unit return bus and the RegFile write port (we / write_addr / write_data).

Parameters:
- MAX_WAIT, 2, cycles a valid long-unit result may be refused before it gains priority over pipeline writeback
- NUM_REGS, 32, architectural register count (x0 hard-wired zero)

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous reset, active-high
- id_valid  input  1  decode stage holds a valid instruction
- id_rs1  input  reg_ind_t  source register 1 of decoding instruction
- id_rs2  input  reg_ind_t  source register 2
- id_rd  input  reg_ind_t  destination register
- id_rd_we  input  1  instruction writes id_rd
- id_long  input  1  result comes from the long-latency unit
- id_stall  output  1  hold decode this cycle
- pwb_valid  input  1  pipeline writeback request
- pwb_rd  input  reg_ind_t  pipeline writeback register
- pwb_data  input  data_t  pipeline writeback value
- pwb_ready  output  1  pipeline writeback accepted this cycle
- lu_valid  input  1  long-unit result valid
- lu_rd  input  reg_ind_t  long-unit destination
- lu_data  input  data_t  long-unit result
- lu_ready  output  1  long-unit result accepted this cycle
- rf_we  output  1  RegFile write enable (registered)
- rf_waddr  output  reg_ind_t  RegFile write address (registered)
- rf_wdata  output  data_t  RegFile write data (registered)

Behaviour:
- Reset (async, immediate): pending[all]=0, wait_cnt=0, rf_we=0, rf_waddr=0, rf_wdata=0. Combinational outputs follow from the cleared state.
- Reset mid-operation drops all pending bits and any in-flight accept. Producers must reissue.
- Scoreboard update on a decode fire (id_valid & !id_stall & id_rd_we & id_long & id_rd!=0): pending[id_rd] set at the next edge.
- Scoreboard clear on a long-unit accept (lu_valid & lu_ready): pending[lu_rd] cleared at the next edge.
- Set and clear of different regs in one cycle: both apply. Same reg in one cycle is impossible, because WAW stalls the issue.
- pending[0] is never set.
- id_stall = id_valid & (pending[id_rs1] | pending[id_rs2] | (id_rd_we & pending[id_rd])), using registered pending only.
- No bypass of a same-cycle clear: the stall lasts one extra cycle after the commit.
- Reads of x0 never stall.
- Arbitration, default: the pipeline has priority. pwb_ready=1 and lu_ready = !pwb_valid.
- Starvation guard: wait_cnt increments each cycle lu_valid & !lu_ready, and resets to 0 on a long-unit accept or when lu_valid=0.
- When wait_cnt >= MAX_WAIT and lu_valid: lu_ready=1 and pwb_ready=0. The WB stage must hold its request.
- At most one accept per cycle.
- The accepted request registers into rf_we/rf_waddr/rf_wdata at the next edge, so the write lands in the RegFile one edge later (1-cycle latency).
- rf_we=0 when there is no accept or the accepted rd==0. Handshake and scoreboard clear still complete for rd==0.
- lu_rd with no pending bit set: the value is still written. No error flag.

Decomposition:
- CorePack (shared package) holds reg_ind_t and data_t, plus a new constant REG_ZERO=0.
- MAX_WAIT stays a module parameter.
- Natural sub-module: rf_scoreboard, holding the pending vector, set/clear ports and hazard lookup for three indices. The arbiter and the output register stay in rf_wb_arbiter.

Test Plan:
- Reset with lu_valid=1, pwb_valid=1 → rf_we=0, pending all 0, wait_cnt=0. After release, the pipeline wins (pwb_ready=1, lu_ready=0).
- Issue long op rd=x5, then next cycle decode rs1=x5 → id_stall=1. Hold until lu result x5=0xDEAD accepted. rf_we/rf_waddr=5/rf_wdata=0xDEAD on the following edge. Stall drops one cycle after the accept.
- Continuous pwb_valid with lu_valid held, MAX_WAIT=2 → lu refused 2 cycles. Third cycle lu_ready=1, pwb_ready=0. Pipeline accepted the cycle after.
- Long-unit result to x0 → lu_ready=1, rf_we=0, no scoreboard change. Decode reading x0 never stalls.
- WAW: long op pending on x7, decode id_rd=x7 with id_rd_we=1 and rs1=rs2=x1 → id_stall=1. id_rd_we=0 → id_stall=0.
- Issue x3 long while an lu result for x9 commits in the same cycle → pending[3]=1 and pending[9]=0 after the edge.
